// File: rtl/multicycle_processor.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// 32x32 register file, registered ALU flags and a memory-ack timeout halt.
module multicycle_processor #(
  parameter int ADDR_W      = 8,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              F_zero,
  output logic              F_overflow,
  output logic              halted,
  output logic [1:0]        err
);
  // state  | meaning
  // FETCH  | read IR at pc, pc += 4 on ack
  // DECODE | read A/B, sign-extend imm, reject illegal encodings
  // EXEC   | ALU op and flags, branch/jump resolve
  // MEM    | lw/sw data access at A+imm
  // WB     | register file write
  // HALT   | frozen until clr
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam int WCW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ACK_TIMEOUT - 1);

  state_t state_q, state_d;
  logic [31:0] regs [32];
  logic [31:0] ir, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [WCW-1:0] wait_q;
  logic [1:0] err_q;
  logic zero_q, ovf_q;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, wb_dst;
  logic legal, ack_timeout, alu_ovf;
  logic [31:0] sum_ab, diff_ab, sum_ai, alu_res, br_full, jmp_full;
  logic unused_bits;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign fn       = ir[5:0];
  assign wb_dst   = (op == OP_R) ? rd : rt;
  assign jmp_full = {4'd0, ir[25:0], 2'b00};
  assign br_full  = 32'(pc_q) + {imm_q[29:0], 2'b00};
  assign unused_bits = ^{ir[10:6], br_full, jmp_full};

  assign pc         = pc_q;
  assign state      = state_q;
  assign F_zero     = zero_q;
  assign F_overflow = ovf_q;
  assign err        = err_q;
  assign halted     = (state_q == S_HALT);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:                             legal = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
  end

  always_comb begin
    sum_ab  = a_q + b_q;
    diff_ab = a_q - b_q;
    sum_ai  = a_q + imm_q;
    alu_res = sum_ai;
    alu_ovf = 1'b0;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADD: begin
            alu_res = sum_ab;
            alu_ovf = (a_q[31] == b_q[31]) && (sum_ab[31] != a_q[31]);
          end
          FN_SUB: begin
            alu_res = diff_ab;
            alu_ovf = (a_q[31] != b_q[31]) && (diff_ab[31] != a_q[31]);
          end
          FN_AND:  alu_res = a_q & b_q;
          FN_OR:   alu_res = a_q | b_q;
          FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
          default: alu_res = '0;
        endcase
      end
      OP_ADDI: alu_ovf = (a_q[31] == imm_q[31]) && (sum_ai[31] != a_q[31]);
      OP_BEQ:  alu_res = diff_ab;
      OP_J:    alu_res = jmp_full;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc_q;
    mem_wdata   = '0;
    ack_timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = S_DECODE;
        else if (wait_q == WAIT_LAST) begin
          state_d     = S_HALT;
          ack_timeout = 1'b1;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (op)
          OP_BEQ, OP_J: state_d = S_FETCH;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = alu_q[ADDR_W-1:0];
        if (op == OP_SW) mem_wdata = b_q;
        if (mem_ack) state_d = (op == OP_SW) ? S_FETCH : S_WB;
        else if (wait_q == WAIT_LAST) begin
          state_d     = S_HALT;
          ack_timeout = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q   <= ADDR_W'(RESET_PC);
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      alu_q  <= '0;
      mdr_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 2'b00;
      wait_q <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      // Counts only consecutive unacked cycles of an active request.
      if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ack)
        wait_q <= ack_timeout ? '0 : wait_q + 1'b1;
      else
        wait_q <= '0;
      if (ack_timeout) err_q <= 2'b10;
      case (state_q)
        S_FETCH: if (mem_ack) begin
          ir   <= mem_rdata;
          pc_q <= pc_q + ADDR_W'(4);
        end
        S_DECODE: begin
          a_q   <= regs[rs];
          b_q   <= regs[rt];
          imm_q <= {{16{ir[15]}}, ir[15:0]};
          if (!legal) err_q <= 2'b01;
        end
        S_EXEC: begin
          alu_q  <= alu_res;
          zero_q <= (alu_res == 32'd0);
          ovf_q  <= alu_ovf;
          if (op == OP_BEQ && a_q == b_q) pc_q <= br_full[ADDR_W-1:0];
          if (op == OP_J)                 pc_q <= jmp_full[ADDR_W-1:0];
        end
        S_MEM: if (mem_ack && op == OP_LW) mdr_q <= mem_rdata;
        S_WB: if (wb_dst != 5'd0) regs[wb_dst] <= (op == OP_LW) ? mdr_q : alu_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: word memory model with
// programmable ack latency, hand-computed expectations checked by assertions.
module tb_multicycle_processor;
  logic        clk = 1'b0;
  logic        clr;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  state;
  logic        F_zero, F_overflow, halted;
  logic [1:0]  err;

  logic [31:0] mem [64];
  logic        ld_en, mem_clear, ack_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  int          ack_delay;
  int          wait_cyc = 0;
  int          tests = 0;
  int          fails = 0;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4, S_HALT = 3'd7;

  always #5 clk = ~clk;

  multicycle_processor #(.ADDR_W(8), .RESET_PC(0), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .clr(clr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc(pc), .state(state), .F_zero(F_zero),
    .F_overflow(F_overflow), .halted(halted), .err(err)
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ack   = ack_en && mem_req && (wait_cyc >= ack_delay);

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ld_en) mem[ld_addr] <= ld_data;
    else if (!clr && mem_req && mem_we && mem_ack) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cyc <= wait_cyc + 1;
    else                     wait_cyc <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (state !== s && n < 300);
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_addr = 6'(a);
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  initial begin
    clr = 1'b1; ld_en = 1'b0; mem_clear = 1'b1; ack_en = 1'b1; ack_delay = 0;
    ld_addr = '0; ld_data = '0;
    @(posedge clk); #1;
    mem_clear = 1'b0;
    load(0,  32'h20010005);  // addi $1,$0,5
    load(1,  32'h20020005);  // addi $2,$0,5
    load(2,  32'h10220002);  // beq  $1,$2,+2
    load(5,  32'hAC010040);  // sw   $1,0x40($0)
    load(6,  32'h8C030040);  // lw   $3,0x40($0)
    load(7,  32'hAC030044);  // sw   $3,0x44($0)
    load(8,  32'h8C040048);  // lw   $4,0x48($0)
    load(9,  32'h20060001);  // addi $6,$0,1
    load(10, 32'h00863820);  // add  $7,$4,$6
    load(11, 32'hAC07004C);  // sw   $7,0x4C($0)
    load(12, 32'h00E4402A);  // slt  $8,$7,$4
    load(13, 32'hAC080050);  // sw   $8,0x50($0)
    load(14, 32'h08000018);  // j    0x60
    load(18, 32'h7FFFFFFF);
    load(24, 32'h00064822);  // sub  $9,$0,$6
    load(25, 32'hAC090054);  // sw   $9,0x54($0)
    load(26, 32'hFC000000);  // illegal opcode 0x3F

    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_flags", 32'({F_zero, F_overflow}), 32'h0);
    chk("rst_halted_err", 32'({halted, err}), 32'h0);
    clr = 1'b0;
    #1;
    chk("rel_mem_req", 32'(mem_req), 32'h1);
    chk("rel_mem_addr", 32'(mem_addr), 32'h0);

    @(posedge clk); #1;
    chk("fetch1_state", 32'(state), 32'(S_DECODE));
    chk("fetch1_pc", 32'(pc), 32'h4);
    repeat (10) @(posedge clk);
    #1;
    chk("beq_pc", 32'(pc), 32'h14);
    chk("beq_state", 32'(state), 32'(S_FETCH));
    chk("beq_zero", 32'(F_zero), 32'h1);
    chk("beq_ovf", 32'(F_overflow), 32'h0);

    ack_delay = 3;
    wait_state(S_MEM, "sw_reach_mem");
    chk("sw_req", 32'(mem_req), 32'h1);
    chk("sw_we", 32'(mem_we), 32'h1);
    chk("sw_addr", 32'(mem_addr), 32'h40);
    chk("sw_wdata", mem_wdata, 32'h5);
    wait_state(S_FETCH, "sw_done");
    wait_state(S_MEM, "lw_reach_mem");
    chk("lw_we", 32'(mem_we), 32'h0);
    chk("lw_addr", 32'(mem_addr), 32'h40);
    wait_state(S_FETCH, "lw_done");
    wait_state(S_MEM, "sw3_reach_mem");
    chk("sw3_addr", 32'(mem_addr), 32'h44);
    chk("lw_result_r3", mem_wdata, 32'h5);
    wait_state(S_FETCH, "sw3_done");
    chk("mem_0x40", mem[16], 32'h5);
    chk("mem_0x44", mem[17], 32'h5);

    ack_delay = 0;
    wait_state(S_WB, "lw4_wb");
    wait_state(S_WB, "addi6_wb");
    wait_state(S_WB, "add7_wb");
    chk("add_ovf", 32'(F_overflow), 32'h1);
    chk("add_zero", 32'(F_zero), 32'h0);
    wait_state(S_HALT, "prog_halt");
    chk("add_result", mem[19], 32'h80000000);
    chk("slt_result", mem[20], 32'h1);
    chk("sub_result", mem[21], 32'hFFFFFFFF);
    chk("ill_pc_after_j", 32'(pc), 32'h6C);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_halted", 32'(halted), 32'h1);
    chk("halt_flags_hold", 32'(F_overflow), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("halt_pc_hold", 32'(pc), 32'h6C);
    chk("halt_no_req", 32'(mem_req), 32'h0);

    clr = 1'b1;
    @(posedge clk); #1;
    load(0, 32'hFC000000);
    chk("clr_from_halt_state", 32'(state), 32'(S_FETCH));
    chk("clr_from_halt_err", 32'({halted, err}), 32'h0);
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ill0_state", 32'(state), 32'(S_HALT));
    chk("ill0_err", 32'(err), 32'h1);
    chk("ill0_pc", 32'(pc), 32'h4);
    repeat (3) @(posedge clk);
    #1;
    chk("ill0_pc_hold", 32'(pc), 32'h4);

    clr = 1'b1;
    @(posedge clk); #1;
    ack_en = 1'b0;
    clr = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("to15_state", 32'(state), 32'(S_FETCH));
    chk("to15_req", 32'(mem_req), 32'h1);
    @(posedge clk); #1;
    chk("to16_state", 32'(state), 32'(S_HALT));
    chk("to16_err", 32'(err), 32'h2);
    chk("to16_req", 32'(mem_req), 32'h0);
    chk("to16_halted", 32'(halted), 32'h1);

    clr = 1'b1;
    @(posedge clk); #1;
    load(0, 32'h8C030040);  // lw $3,0x40($0)
    ack_en = 1'b1;
    ack_delay = 2;
    clr = 1'b0;
    wait_state(S_MEM, "midmem_reach");
    chk("midmem_addr", 32'(mem_addr), 32'h40);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("midmem_clr_state", 32'(state), 32'(S_FETCH));
    chk("midmem_clr_addr", 32'(mem_addr), 32'h0);
    chk("midmem_clr_req", 32'(mem_req), 32'h1);
    ack_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_ignores_ack_pc", 32'(pc), 32'h0);
    chk("clr_ignores_ack_state", 32'(state), 32'(S_FETCH));
    clr = 1'b0;
    @(posedge clk); #1;
    chk("restart_state", 32'(state), 32'(S_DECODE));
    chk("restart_pc", 32'(pc), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
